// File: rtl/morse_player.sv
// rtl/morse_player.sv - plays a 10-bit morse word as a timed on/off LED/buzzer signal
// Optional feature macro: MORSE_PLAYER_LOOP_EN (adds loop input and WORD inter-pass gap state)
module morse_player #(
  parameter int DOT_TICKS      = 25000000,
  parameter int LINE_TICKS     = 75000000,
  parameter int GAP_TICKS      = 25000000,
  parameter int CNT_W          = 28
`ifdef MORSE_PLAYER_LOOP_EN
  , parameter int WORD_GAP_TICKS = 175000000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] code,
`ifdef MORSE_PLAYER_LOOP_EN
  input  logic       loop,
`endif
  output logic       signal_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] symbol,
  output logic [2:0] sent
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ON,
    GAP,
    DONE
`ifdef MORSE_PLAYER_LOOP_EN
    , WORD
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         sent_q, sent_d;
  logic               finish;
`ifdef MORSE_PLAYER_LOOP_EN
  logic [9:0]         code_q, code_d;
`endif

  // State, shift register, tick counter and symbol count; reset aborts playback
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
`ifdef MORSE_PLAYER_LOOP_EN
      code_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
`ifdef MORSE_PLAYER_LOOP_EN
      code_q  <= code_d;
`endif
    end
  end

  // Next-state logic: decode the head symbol, time high/low phases, end or loop the word
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    finish  = 1'b0;
`ifdef MORSE_PLAYER_LOOP_EN
    code_d  = code_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = code;
          sent_d  = '0;
          cnt_d   = '0;
          state_d = LOAD;
`ifdef MORSE_PLAYER_LOOP_EN
          code_d  = code;
`endif
        end
      end
      LOAD: begin
        case (shreg_q[9:8])
          2'b01: begin state_d = ON; cnt_d = CNT_W'(DOT_TICKS - 1); end
          2'b11: begin state_d = ON; cnt_d = CNT_W'(LINE_TICKS - 1); end
          default: finish = 1'b1;
        endcase
      end
      ON: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_TICKS - 1);
          shreg_d = {shreg_q[7:0], 2'b00};
          sent_d  = sent_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // A valid next symbol starts straight away; an end marker takes the LOAD path
          if (sent_q == 3'd5) begin
            finish = 1'b1;
          end else if (shreg_q[9:8] == 2'b01) begin
            state_d = ON;
            cnt_d   = CNT_W'(DOT_TICKS - 1);
          end else if (shreg_q[9:8] == 2'b11) begin
            state_d = ON;
            cnt_d   = CNT_W'(LINE_TICKS - 1);
          end else begin
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
`ifdef MORSE_PLAYER_LOOP_EN
      WORD: begin
        if (cnt_q == '0) begin
          shreg_d = code_q;
          sent_d  = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
`ifdef MORSE_PLAYER_LOOP_EN
      if (loop) begin
        state_d = WORD;
        cnt_d   = CNT_W'(WORD_GAP_TICKS - 1);
      end
`endif
    end
  end

  assign signal_out = (state_q == ON);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign symbol     = (state_q == ON) ? shreg_q[9:8] : 2'b00;
  assign sent       = sent_q;

endmodule

// File: tb/tb_morse_player.sv
// tb/tb_morse_player.sv - self-checking bench for morse_player
module tb_morse_player;

  localparam int DOT  = 2;
  localparam int LINE = 6;
  localparam int GAP  = 2;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [9:0] code;
  logic       signal_out;
  logic       busy;
  logic       done;
  logic [1:0] symbol;
  logic [2:0] sent;
`ifdef MORSE_PLAYER_LOOP_EN
  logic       loop;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sig;
    logic       busy;
    logic       done;
    logic [1:0] sym;
    logic [2:0] sent;
  } exp_t;

  typedef struct {
    logic [9:0] code;
    int         done_cyc;
    int         sent_n;
    int         restart;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  morse_player #(
    .DOT_TICKS(DOT),
    .LINE_TICKS(LINE),
    .GAP_TICKS(GAP),
    .CNT_W(28)
`ifdef MORSE_PLAYER_LOOP_EN
    , .WORD_GAP_TICKS(4)
`endif
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .code(code),
`ifdef MORSE_PLAYER_LOOP_EN
    .loop(loop),
`endif
    .signal_out(signal_out),
    .busy(busy),
    .done(done),
    .symbol(symbol),
    .sent(sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic b, input logic d, input logic [1:0] y, input int n);
    exp_t e;
    e.sig = s; e.busy = b; e.done = d; e.sym = y; e.sent = 3'(n);
    sb.push_back(e);
  endtask

  // Expected per-cycle outputs from cycle 1 (LOAD) through the first idle cycle
  task automatic gen_expect(input logic [9:0] c);
    int n;
    int len;
    logic [1:0] s;
    push(1'b0, 1'b1, 1'b0, 2'b00, 0);
    n = 0;
    while (n < 5) begin
      s = c[(9 - 2*n) -: 2];
      if (s != 2'b01 && s != 2'b11) begin
        if (n > 0) push(1'b0, 1'b1, 1'b0, 2'b00, n);
        break;
      end
      len = (s == 2'b01) ? DOT : LINE;
      repeat (len) push(1'b1, 1'b1, 1'b0, s, n);
      repeat (GAP) push(1'b0, 1'b1, 1'b0, 2'b00, n + 1);
      n++;
    end
    push(1'b0, 1'b1, 1'b1, 2'b00, n);
    push(1'b0, 1'b0, 1'b0, 2'b00, n);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int cyc;
    int done_at;
    cyc = 0;
    done_at = -1;
    gen_expect(v.code);
    @(negedge clock);
    start = 1'b1;
    code  = v.code;
    @(posedge clock);
    #1;
    start = 1'b0;
    code  = 10'($urandom);
    while (sb.size() > 0) begin
      @(negedge clock);
      cyc++;
      e = sb.pop_front();
      chk($sformatf("wave c=%b cyc=%0d {sig,busy,done,sym,sent}", v.code, cyc),
          int'({signal_out, busy, done, symbol, sent}),
          int'({e.sig, e.busy, e.done, e.sym, e.sent}));
      if (done && done_at < 0) done_at = cyc;
      if (cyc == v.restart) begin
        start = 1'b1;
        code  = 10'b1111111111;
      end else if (cyc == v.restart + 1) begin
        start = 1'b0;
      end
    end
    chk($sformatf("done_cycle c=%b", v.code), done_at, v.done_cyc);
    chk($sformatf("final_sent c=%b", v.code), int'(sent), v.sent_n);
  endtask

  initial begin
    int done_cnt;
    vecs[0] = '{code: 10'b0111000000, done_cyc: 15, sent_n: 2, restart: -1};
    vecs[1] = '{code: 10'b0101010101, done_cyc: 22, sent_n: 5, restart: -1};
    vecs[2] = '{code: 10'b0000000000, done_cyc: 2,  sent_n: 0, restart: -1};
    vecs[3] = '{code: 10'b1001010101, done_cyc: 2,  sent_n: 0, restart: -1};
    vecs[4] = '{code: 10'b0111000000, done_cyc: 15, sent_n: 2, restart: 4};
    vecs[5] = '{code: 10'b1101110000, done_cyc: 23, sent_n: 3, restart: -1};
    vecs[6] = '{code: 10'b0111010111, done_cyc: 30, sent_n: 5, restart: -1};

    resetn = 1'b0;
    start  = 1'b0;
    code   = '0;
`ifdef MORSE_PLAYER_LOOP_EN
    loop   = 1'b0;
`endif
    #1;
    chk("reset outputs", int'({signal_out, busy, done, symbol, sent}), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle after reset", int'({signal_out, busy, done, symbol, sent}), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start held high: re-accepted in the first idle cycle after done
    @(negedge clock);
    start = 1'b1;
    code  = 10'b0100000000;
    @(posedge clock);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      chk($sformatf("held start cyc=%0d {sig,busy,done}", c),
          int'({signal_out, busy, done}),
          int'({(c == 2 || c == 3 || c == 10), (c != 8), (c == 7)}));
    end
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk("held start drains", int'(busy), 0);

`ifdef MORSE_PLAYER_LOOP_EN
    // looping single dot, loop dropped during the second pass
    loop = 1'b1;
    @(negedge clock);
    start = 1'b1;
    code  = 10'b0100000000;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      chk($sformatf("loop cyc=%0d {sig,busy,done}", c),
          int'({signal_out, busy, done}),
          int'({(c == 2 || c == 3 || c == 12 || c == 13), (c <= 17), (c == 17)}));
      if (c == 13) loop = 1'b0;
    end
`endif

    // asynchronous reset in the middle of a line
    @(negedge clock);
    start = 1'b1;
    code  = 10'b0111000000;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clock);
    chk("mid-line high before reset", int'({signal_out, symbol}), int'({1'b1, 2'b11}));
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset clears outputs", int'({signal_out, busy, done, symbol, sent}), 0);
    @(negedge clock);
    resetn = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done || busy || signal_out) done_cnt++;
    end
    chk("no activity after reset release", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
